alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_pkg.sv | 39 +++
 rtl/sync_fifo.sv | 59 +++++
 rtl/alu_issue.sv | 226 ++++++++++++++++++++++
 tb/tb_alu_issue.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue block: opcodes, FSM states and
// the bit positions of the {CF,OF,SF,ZF} flags word.
package alu_pkg;

    // Opcode map; every code not listed here is illegal.
    localparam logic [3:0] OP_LDI = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_NEG = 4'b0111;

    // Bit positions inside the 4-bit FLAGS word {CF,OF,SF,ZF}.
    localparam int FLAG_CF = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_SF = 1;
    localparam int FLAG_ZF = 0;

    // Issue sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_e;

    // True for opcodes that are routed through the downstream ALU.
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_XOR) || (op == OP_NEG);
    endfunction

    // True for every opcode the issue unit knows how to handle.
    function automatic logic is_legal(input logic [3:0] op);
        return (op == OP_LDI) || is_alu_op(op);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// 'head' whenever the FIFO is non-empty, so the consumer can capture it in
// the same cycle it pops. Pointers carry one extra wrap bit so that full
// and empty can be told apart when the index bits are equal.
module sync_fifo #(
    parameter int PW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [PW-1:0] push_data,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [PW-1:0] head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [PW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr_reg;
    logic [AW:0]   rd_ptr_reg;
    logic          push_fire;
    logic          pop_fire;

    // Requests are gated here so the caller never corrupts the pointers.
    assign push_fire = push && !full;
    assign pop_fire  = pop && !empty;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign head  = mem[rd_ptr_reg[AW-1:0]];

    // Storage array: written on accepted pushes only, no reset needed.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    // Read/write pointers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop_fire) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/alu_issue.sv
// In-order, one-at-a-time instruction issue unit. Instructions queue in a
// small FIFO, are decoded against an eight-entry register file, driven to
// an external registered ALU for ALU_LAT enabled cycles and written back.
module alu_issue
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_opcode,
    input  logic [2:0]       in_rd,
    input  logic [2:0]       in_rs1,
    input  logic [2:0]       in_rs2,
    input  logic [WIDTH-1:0] in_imm,
    output logic             alu_en,
    output logic             alu_oe,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cf,
    input  logic             alu_of,
    input  logic             alu_sf,
    input  logic             alu_zf,
    output logic             wb_valid,
    output logic [2:0]       wb_rd,
    output logic [WIDTH-1:0] wb_data,
    output logic [3:0]       flags,
    output logic             busy,
    output logic             err,
    input  logic [2:0]       rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    // FIFO payload layout: {opcode, rd, rs1, rs2, imm}.
    localparam int PW = 4 + 3 + 3 + 3 + WIDTH;
    localparam int CW = $clog2(ALU_LAT + 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LOAD = CW'(ALU_LAT);

    state_e           state_reg;
    state_e           state_next;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [PW-1:0]    fifo_head;
    logic [PW-1:0]    push_payload;

    // Instruction register, loaded on pop.
    logic [3:0]       ir_op_reg;
    logic [2:0]       ir_rd_reg;
    logic [2:0]       ir_rs1_reg;
    logic [2:0]       ir_rs2_reg;
    logic [WIDTH-1:0] ir_imm_reg;

    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] alu_a_reg;
    logic [WIDTH-1:0] alu_b_reg;
    logic [3:0]       alu_opcode_reg;
    logic [3:0]       flags_reg;
    logic             err_reg;
    logic [3:0]       alu_flags;
    logic [WIDTH-1:0] regs_reg [8];

    assign push_payload = {in_opcode, in_rd, in_rs1, in_rs2, in_imm};

    sync_fifo #(
        .PW    (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data (push_payload),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // Ready depends only on occupancy, never on a same-cycle pop.
    assign in_ready = !fifo_full;

    // Gather the ALU's flag inputs into the shared FLAGS bit order.
    always_comb begin
        alu_flags          = '0;
        alu_flags[FLAG_CF] = alu_cf;
        alu_flags[FLAG_OF] = alu_of;
        alu_flags[FLAG_SF] = alu_sf;
        alu_flags[FLAG_ZF] = alu_zf;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and the FIFO pop strobe.
    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (ir_op_reg == OP_LDI) begin
                    state_next = ST_WB;
                end else if (is_alu_op(ir_op_reg)) begin
                    state_next = ST_EXEC;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_EXEC: begin
                // The last enabled cycle is the one where the count reads 1.
                if (cnt_reg <= CNT_ONE) begin
                    state_next = ST_WB;
                end
            end
            ST_WB: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Instruction register capture on pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_op_reg  <= '0;
            ir_rd_reg  <= '0;
            ir_rs1_reg <= '0;
            ir_rs2_reg <= '0;
            ir_imm_reg <= '0;
        end else if (pop) begin
            {ir_op_reg, ir_rd_reg, ir_rs1_reg, ir_rs2_reg, ir_imm_reg} <= fifo_head;
        end
    end

    // Operand/opcode latch in DECODE; these stay put through EXEC and WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            alu_opcode_reg <= '0;
        end else if (state_reg == ST_DECODE) begin
            alu_a_reg      <= regs_reg[ir_rs1_reg];
            alu_b_reg      <= regs_reg[ir_rs2_reg];
            alu_opcode_reg <= ir_op_reg;
        end
    end

    // EXEC down-counter: loaded in DECODE, decremented per enabled cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (state_reg == ST_DECODE) begin
            cnt_reg <= CNT_LOAD;
        end else if (state_reg == ST_EXEC && cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CNT_ONE;
        end
    end

    // Sticky illegal-opcode flag, raised while decoding an unknown opcode.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (state_reg == ST_DECODE && !is_legal(ir_op_reg)) begin
            err_reg <= 1'b1;
        end
    end

    // FLAGS capture at writeback of ALU ops; LDI leaves them untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_reg <= '0;
        end else if (state_reg == ST_WB && ir_op_reg != OP_LDI) begin
            flags_reg <= alu_flags;
        end
    end

    // Register file write at writeback; a reset clears every entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (state_reg == ST_WB) begin
            regs_reg[ir_rd_reg] <= wb_data;
        end
    end

    // Writeback bus is combinational from the IR and the ALU result.
    assign wb_valid = (state_reg == ST_WB);
    assign wb_rd    = ir_rd_reg;
    assign wb_data  = (ir_op_reg == OP_LDI) ? ir_imm_reg : alu_result;

    assign alu_en     = (state_reg == ST_EXEC);
    assign alu_oe     = (state_reg == ST_EXEC) || (state_reg == ST_WB);
    assign alu_a      = alu_a_reg;
    assign alu_b      = alu_b_reg;
    assign alu_opcode = alu_opcode_reg;

    assign flags = flags_reg;
    assign err   = err_reg;
    assign busy  = (state_reg != ST_IDLE) || !fifo_empty;

    // Debug read returns the pre-writeback value in a writeback cycle.
    assign rd_data = regs_reg[rd_addr];

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed vector table, illegal opcode,
// FIFO back-pressure, reset during EXEC and a randomized in-order run
// checked against a simple architectural model.
module tb_alu_issue;

    localparam int WIDTH   = 8;
    localparam int DEPTH   = 4;
    localparam int ALU_LAT = 2;

    localparam logic [3:0] C_LDI = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_SUB = 4'b0011;
    localparam logic [3:0] C_AND = 4'b0100;
    localparam logic [3:0] C_OR  = 4'b0101;
    localparam logic [3:0] C_XOR = 4'b0110;
    localparam logic [3:0] C_NEG = 4'b0111;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       in_opcode = '0;
    logic [2:0]       in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [WIDTH-1:0] in_imm = '0;
    logic             alu_en, alu_oe;
    logic [3:0]       alu_opcode;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [WIDTH-1:0] alu_result = '0;
    logic             alu_cf = 1'b0, alu_of = 1'b0, alu_sf = 1'b0, alu_zf = 1'b0;
    logic             wb_valid;
    logic [2:0]       wb_rd;
    logic [WIDTH-1:0] wb_data;
    logic [3:0]       flags;
    logic             busy, err;
    logic [2:0]       rd_addr = '0;
    logic [WIDTH-1:0] rd_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_issue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .alu_en(alu_en), .alu_oe(alu_oe), .alu_opcode(alu_opcode),
        .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .alu_cf(alu_cf),
        .alu_of(alu_of), .alu_sf(alu_sf), .alu_zf(alu_zf), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .wb_data(wb_data), .flags(flags), .busy(busy), .err(err),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    // Arithmetic reference: returns {CF,OF,SF,ZF,result} using plain integers.
    function automatic logic [11:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int ua, ub, sa, sb, r, sr;
        logic cf, of;
        logic [7:0] res;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        r = 0; sr = 0; cf = 1'b0; of = 1'b0;
        case (op)
            C_ADD: begin r = ua + ub; sr = sa + sb; cf = (r > 255); of = (sr > 127) || (sr < -128); end
            C_SUB: begin r = ua - ub; sr = sa - sb; cf = (ua < ub); of = (sr > 127) || (sr < -128); end
            C_NEG: begin r = -ua; sr = -sa; cf = (ua != 0); of = (sr > 127); end
            C_AND: r = ua & ub;
            C_OR:  r = ua | ub;
            C_XOR: r = ua ^ ub;
            default: r = 0;
        endcase
        res = r[7:0];
        return {cf, of, res[7], (res == 8'h00), res};
    endfunction

    // Downstream registered ALU.
    always @(posedge clk) begin
        if (alu_en) begin
            {alu_cf, alu_of, alu_sf, alu_zf, alu_result} <= alu_ref(alu_opcode, alu_a, alu_b);
        end
    end

    typedef struct {
        logic [2:0] rd;
        logic [7:0] data;
    } wb_t;
    wb_t wb_log[$];

    // Writeback monitor.
    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            wb_log.push_back('{wb_rd, wb_data});
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic [7:0] imm, output int waited);
        @(negedge clk);
        in_valid = 1'b1; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        waited = 0;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("push_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_wb(output int lat, output int en_cycles);
        lat = 0; en_cycles = 0;
        do begin
            @(negedge clk);
            lat++;
            if (alu_en) en_cycles++;
        end while (!wb_valid && lat < 50);
    endtask

    typedef struct {
        logic [3:0] op;
        logic [2:0] rd, rs1, rs2;
        logic [7:0] imm;
        logic [7:0] exp_data;
        logic [3:0] exp_flags;
    } vec_t;

    initial begin
        vec_t       tbl[10];
        logic [7:0] mregs[8];
        logic [3:0] mflags;
        logic       merr;
        logic [11:0] r12;
        wb_t        exp_q[$];
        int         waited, lat, en_cycles, cnt, gap;
        logic [3:0] op;
        logic [2:0] rd, rs1, rs2;
        logic [7:0] imm;

        tbl[0] = '{C_LDI, 3'd1, 3'd0, 3'd0, 8'h7F, 8'h7F, 4'b0000};
        tbl[1] = '{C_LDI, 3'd2, 3'd0, 3'd0, 8'h01, 8'h01, 4'b0000};
        tbl[2] = '{C_ADD, 3'd3, 3'd1, 3'd2, 8'h00, 8'h80, 4'b0110};
        tbl[3] = '{C_LDI, 3'd4, 3'd0, 3'd0, 8'h05, 8'h05, 4'b0110};
        tbl[4] = '{C_SUB, 3'd5, 3'd4, 3'd4, 8'h00, 8'h00, 4'b0001};
        tbl[5] = '{C_XOR, 3'd6, 3'd1, 3'd2, 8'h00, 8'h7E, 4'b0000};
        tbl[6] = '{C_NEG, 3'd7, 3'd2, 3'd0, 8'h00, 8'hFF, 4'b1010};
        tbl[7] = '{C_AND, 3'd0, 3'd1, 3'd3, 8'h00, 8'h00, 4'b0001};
        tbl[8] = '{C_SUB, 3'd0, 3'd2, 3'd1, 8'h00, 8'h82, 4'b1010};
        tbl[9] = '{C_OR,  3'd6, 3'd3, 3'd4, 8'h00, 8'h85, 4'b0010};

        for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
        mflags = 4'h0; merr = 1'b0;

        // Reset state.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_in_ready", in_ready, 1);
        check("reset_wb_valid", wb_valid, 0);
        check("reset_alu_en", alu_en, 0);
        check("reset_alu_oe", alu_oe, 0);
        check("reset_alu_ops", {alu_opcode, alu_a, alu_b}, 0);
        check("reset_flags", flags, 0);
        check("reset_err", err, 0);
        check("reset_busy", busy, 0);

        // Directed vector table.
        foreach (tbl[i]) begin
            push(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, waited);
            wait_wb(lat, en_cycles);
            check("vec_wb_valid", wb_valid, 1);
            check("vec_latency", lat, (tbl[i].op == C_LDI) ? 3 : 3 + ALU_LAT);
            check("vec_en_cycles", en_cycles, (tbl[i].op == C_LDI) ? 0 : ALU_LAT);
            check("vec_wb_oe", {alu_oe, alu_en}, 2'b10);
            check("vec_wb_rd", wb_rd, tbl[i].rd);
            check("vec_wb_data", wb_data, tbl[i].exp_data);
            rd_addr = tbl[i].rd;
            #1;
            check("vec_old_read", rd_data, mregs[tbl[i].rd]);
            @(negedge clk);
            check("vec_flags", flags, tbl[i].exp_flags);
            check("vec_rd_data", rd_data, tbl[i].exp_data);
            mregs[tbl[i].rd] = tbl[i].exp_data;
            mflags = tbl[i].exp_flags;
            $display("vec %0d op=%b rd=%0d wb=%h flags=%b lat=%0d", i, tbl[i].op, tbl[i].rd, wb_data, flags, lat);
        end

        // Illegal opcode: sticky ERR, no writeback, next instruction still runs.
        push(4'b1111, 3'd5, 3'd1, 3'd2, 8'hAA, waited);
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (wb_valid) cnt++;
        end
        check("illegal_no_wb", cnt, 0);
        check("illegal_err", err, 1);
        check("illegal_flags_kept", flags, mflags);
        push(C_LDI, 3'd2, 3'd0, 3'd0, 8'h33, waited);
        wait_wb(lat, en_cycles);
        check("after_illegal_latency", lat, 3);
        check("after_illegal_data", wb_data, 8'h33);
        @(negedge clk);
        check("err_sticky", err, 1);
        mregs[2] = 8'h33;
        merr = 1'b1;
        $display("illegal opcode: err=%0d, following LDI wrote %h", err, 8'h33);

        // Back-pressure: an ADD keeps the FSM busy while DEPTH+1 LDIs arrive.
        wb_log.delete();
        exp_q.delete();
        r12 = alu_ref(C_ADD, mregs[1], mregs[2]);
        exp_q.push_back('{3'd3, r12[7:0]});
        mregs[3] = r12[7:0];
        mflags = r12[11:8];
        push(C_ADD, 3'd3, 3'd1, 3'd2, 8'h00, waited);
        for (int k = 0; k < DEPTH + 1; k++) begin
            imm = 8'h11 * (k + 1);
            rd  = 3'(4 + k);
            push(C_LDI, rd, 3'd0, 3'd0, imm, waited);
            if (k < DEPTH) check("fifo_no_wait", waited, 0);
            else           check("fifo_held", (waited > 0) ? 1 : 0, 1);
            exp_q.push_back('{rd, imm});
            mregs[rd] = imm;
            $display("fifo push %0d rd=%0d imm=%h waited=%0d", k, rd, imm, waited);
        end
        cnt = 0;
        while (busy && cnt < 500) begin
            @(negedge clk);
            cnt++;
        end
        check("fifo_drain", busy, 0);
        check("fifo_wb_count", wb_log.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < wb_log.size(); k++) begin
            check("fifo_wb_order", {wb_log[k].rd, wb_log[k].data}, {exp_q[k].rd, exp_q[k].data});
        end
        check("fifo_flags", flags, mflags);

        // Reset in the second EXEC cycle of an ADD, with a same-cycle push.
        wb_log.delete();
        push(C_ADD, 3'd3, 3'd1, 3'd2, 8'h00, waited);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k >= 3) check("rst_exec_en", alu_en, 1);
        end
        rst = 1'b1;
        in_valid = 1'b1; in_opcode = C_LDI; in_rd = 3'd1; in_imm = 8'h99;
        @(posedge clk);
        #1 rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_flags", flags, 0);
        check("rst_err", err, 0);
        check("rst_alu", {alu_en, alu_oe, alu_opcode, alu_a, alu_b}, 0);
        for (int r = 0; r < 8; r++) begin
            rd_addr = 3'(r);
            #1;
            check("rst_reg", rd_data, 0);
        end
        repeat (6) @(negedge clk);
        check("rst_no_wb", wb_log.size(), 0);
        for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
        mflags = 4'h0; merr = 1'b0;
        $display("reset during EXEC: no writeback, state cleared");

        // Randomized run against the architectural model.
        wb_log.delete();
        exp_q.delete();
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) == 0) op = 4'($urandom_range(8, 15));
            else if ($urandom_range(0, 2) == 0) op = C_LDI;
            else op = 4'($urandom_range(1, 7));
            rd = 3'($urandom_range(0, 7));
            rs1 = 3'($urandom_range(0, 7));
            rs2 = 3'($urandom_range(0, 7));
            imm = 8'($urandom_range(0, 255));
            if (op == C_LDI) begin
                exp_q.push_back('{rd, imm});
                mregs[rd] = imm;
            end else if (op >= C_ADD && op <= C_NEG) begin
                r12 = alu_ref(op, mregs[rs1], mregs[rs2]);
                exp_q.push_back('{rd, r12[7:0]});
                mregs[rd] = r12[7:0];
                mflags = r12[11:8];
            end else begin
                merr = 1'b1;
            end
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            push(op, rd, rs1, rs2, imm, waited);
            $display("rand %0d op=%b rd=%0d rs1=%0d rs2=%0d imm=%h", n, op, rd, rs1, rs2, imm);
        end
        cnt = 0;
        while (busy && cnt < 3000) begin
            @(negedge clk);
            cnt++;
        end
        check("rand_drain", busy, 0);
        check("rand_wb_count", wb_log.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < wb_log.size(); k++) begin
            check("rand_wb", {wb_log[k].rd, wb_log[k].data}, {exp_q[k].rd, exp_q[k].data});
        end
        for (int r = 0; r < 8; r++) begin
            rd_addr = 3'(r);
            #1;
            check("rand_reg", rd_data, mregs[r]);
        end
        check("rand_flags", flags, mflags);
        check("rand_err", err, merr);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
